// File: rtl/mips_dbg_pkg.sv
// Shared debug-unit definitions: dump FSM state encoding, byte sizing and checksum seed.
package mips_dbg_pkg;

  localparam int unsigned NB_BYTE        = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [7:0]  CSUM_SEED      = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LOAD,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/data_mem_dumper_if.sv
// Valid/ready byte stream from the memory dumper to the debug UART transmitter.
interface data_mem_dumper_if #(
  parameter int unsigned NB_BYTE = 8
);
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;

  modport master (output o_tx_data, output o_tx_valid, input i_tx_ready);
  modport slave  (input o_tx_data, input o_tx_valid, output i_tx_ready);
endinterface

// File: rtl/data_mem_dumper_word_serializer.sv
// word_serializer: shifts a loaded word out MSB byte first on a valid/ready stream;
// a single byte can also be loaded as the last byte of a "word" (checksum trailer).
module word_serializer #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_load_byte,
  input  logic [NB_DATA-1:0] i_word,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_last_hs_c
);
  localparam int unsigned BYTES_PER_W = NB_DATA / NB_BYTE;
  localparam int unsigned IDX_W       = (BYTES_PER_W > 1) ? $clog2(BYTES_PER_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_W - 1);

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               hs;

  assign hs          = valid_q & i_tx_ready;
  assign o_last_hs_c = hs && (idx_q == LAST_IDX);
  assign o_tx_data   = shift_q[NB_DATA-1 -: NB_BYTE];
  assign o_tx_valid  = valid_q;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (i_load) begin
      shift_d = i_word;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (i_load_byte) begin
      // Lone byte sits in the top lane and is treated as the last of its word.
      shift_d = {i_byte, {(NB_DATA-NB_BYTE){1'b0}}};
      idx_d   = LAST_IDX;
      valid_d = 1'b1;
    end else if (hs) begin
      shift_d = shift_q << NB_BYTE;
      idx_d   = idx_q + IDX_W'(1);
      if (idx_q == LAST_IDX) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/data_mem_dumper.sv
// Dumps a word range of the data memory as an MSB-first byte stream for the debug unit.
// Optional DUMP_CHECKSUM_EN appends one XOR checksum byte after the data.
module data_mem_dumper #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 12,
  parameter int unsigned NB_BYTE = mips_dbg_pkg::NB_BYTE
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NB_ADDR-1:0]  i_base_addr,
  input  logic [NB_ADDR-2:0]  i_word_count,
  output logic [NB_ADDR-1:0]  o_mem_addr,
  input  logic [NB_DATA-1:0]  i_mem_data,
  data_mem_dumper_if.master   tx,
  output logic                o_busy,
  output logic                o_done
);
  import mips_dbg_pkg::*;

  localparam int unsigned NB_CNT = NB_ADDR - 1;

  dump_state_e         state_q, state_d;
  logic [NB_ADDR-1:0]  addr_q, addr_d;
  logic [NB_CNT-1:0]   remain_q, remain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ser_load, ser_load_byte, last_hs_c;
  logic [NB_BYTE-1:0]  csum_load_val;

`ifdef DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum_q, csum_d;

  // Running XOR of every data byte handed off; the next value feeds the trailer load.
  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_IDLE && i_start)
      csum_d = NB_BYTE'(CSUM_SEED);
    else if (state_q == ST_SEND && tx.o_tx_valid && tx.i_tx_ready)
      csum_d = csum_q ^ tx.o_tx_data;
  end

  always_ff @(posedge clk) begin
    if (i_rst) csum_q <= NB_BYTE'(CSUM_SEED);
    else       csum_q <= csum_d;
  end

  assign csum_load_val = csum_d;
`else
  assign csum_load_val = '0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    ser_load      = 1'b0;
    ser_load_byte = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d   = {i_base_addr[NB_ADDR-1:2], 2'b00};
          remain_d = i_word_count;
          if (i_word_count == '0) begin
`ifdef DUMP_CHECKSUM_EN
            state_d       = ST_CSUM;
            ser_load_byte = 1'b1;
`else
            state_d       = ST_DONE;
`endif
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: state_d = ST_LOAD;
      ST_LOAD: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (last_hs_c) begin
          remain_d = remain_q - NB_CNT'(1);
          if (remain_q != NB_CNT'(1)) begin
            addr_d  = addr_q + NB_ADDR'(BYTES_PER_WORD);
            state_d = ST_ADDR;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            state_d       = ST_CSUM;
            ser_load_byte = 1'b1;
`else
            state_d       = ST_DONE;
`endif
          end
        end
      end
      ST_CSUM: if (last_hs_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ADDR) || (state_d == ST_LOAD) ||
             (state_d == ST_SEND) || (state_d == ST_CSUM);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_mem_addr = addr_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

  word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_load      (ser_load),
    .i_load_byte (ser_load_byte),
    .i_word      (i_mem_data),
    .i_byte      (csum_load_val),
    .o_tx_data   (tx.o_tx_data),
    .o_tx_valid  (tx.o_tx_valid),
    .i_tx_ready  (tx.i_tx_ready),
    .o_last_hs_c (last_hs_c)
  );

endmodule

// File: tb/tb_data_mem_dumper.sv
// Self-checking bench for data_mem_dumper: scoreboarded byte stream, cycle-exact
// timing, back-pressure, wrap, mid-dump start, reset abort; honours DUMP_CHECKSUM_EN.
module tb_data_mem_dumper;
  localparam int unsigned NB_DATA = 32;
  localparam int unsigned NB_ADDR = 12;
  localparam int unsigned NB_BYTE = 8;

  logic                clk = 1'b0;
  logic                i_rst = 1'b1;
  logic                i_start = 1'b0;
  logic [NB_ADDR-1:0]  i_base_addr = '0;
  logic [NB_ADDR-2:0]  i_word_count = '0;
  logic [NB_ADDR-1:0]  o_mem_addr;
  logic [NB_DATA-1:0]  i_mem_data;
  logic                o_busy;
  logic                o_done;

  data_mem_dumper_if #(.NB_BYTE(NB_BYTE)) tx_if();

  logic [31:0] mem [0:1023];
  assign i_mem_data = mem[o_mem_addr[11:2]];

  always #5 clk = ~clk;

  data_mem_dumper #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR),
    .NB_BYTE (NB_BYTE)
  ) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_word_count (i_word_count),
    .o_mem_addr   (o_mem_addr),
    .i_mem_data   (i_mem_data),
    .tx           (tx_if.master),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;  // 0: ready high, 1: random, 2: driven by hand

  typedef struct {
    logic [7:0]  data;
    logic [11:0] addr;
    bit          chk_addr;
  } exp_byte_t;
  exp_byte_t sb_q[$];

  typedef struct {
    logic [11:0] base;
    logic [10:0] count;
    bit          mid_start;
    int          rmode;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ready_mode == 0)      tx_if.i_tx_ready = 1'b1;
    else if (ready_mode == 1) tx_if.i_tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_byte(input logic [7:0] d, input logic [11:0] a, input bit ca);
    exp_byte_t e;
    e.data = d; e.addr = a; e.chk_addr = ca;
    sb_q.push_back(e);
  endtask

  // Reference model: walk the bench memory the way the dump should.
  task automatic push_model(input logic [11:0] base, input int count);
    logic [11:0] a;
    logic [31:0] w;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]  cs = 8'h00;
`endif
    a = {base[11:2], 2'b00};
    for (int i = 0; i < count; i++) begin
      w = mem[a[11:2]];
      for (int b = 0; b < 4; b++) begin
        push_byte(w[31-8*b -: 8], a, 1'b1);
`ifdef DUMP_CHECKSUM_EN
        cs = cs ^ w[31-8*b -: 8];
`endif
      end
      a = a + 12'd4;
    end
`ifdef DUMP_CHECKSUM_EN
    push_byte(cs, 12'h000, 1'b0);
`endif
  endtask

  task automatic pulse_start(input logic [11:0] base, input logic [10:0] count);
    i_base_addr  = base;
    i_word_count = count;
    i_start      = 1'b1;
    step();
    i_start      = 1'b0;
  endtask

  // Wait (bounded) for o_done; optionally fire a stray start mid-dump.
  task automatic wait_done(input bit mid_start, input string tag);
    int  n = 0;
    bit  seen;
    seen = o_done;
    while (!seen && n < 3000) begin
      if (mid_start && n == 4) begin
        i_base_addr  = 12'h100;
        i_word_count = 11'd3;
        i_start      = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      step();
      n++;
      seen = o_done;
    end
    i_start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    step();
    chk({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
  endtask

  // Stream monitor: pops the scoreboard on each handshake and checks hold behaviour.
  logic       stalled = 1'b0;
  logic [7:0] stall_data = 8'h00;
  always @(negedge clk) begin
    exp_byte_t e;
    if (i_rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", 32'(tx_if.o_tx_valid), 32'd1);
        chk("hold_data", 32'(tx_if.o_tx_data), 32'(stall_data));
      end
      if (tx_if.o_tx_valid && tx_if.i_tx_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_if.o_tx_data);
        end else begin
          e = sb_q.pop_front();
          chk("byte", 32'(tx_if.o_tx_data), 32'(e.data));
          if (e.chk_addr) chk("byte_addr", 32'(o_mem_addr), 32'(e.addr));
        end
      end
      stalled    = tx_if.o_tx_valid && !tx_if.i_tx_ready;
      stall_data = tx_if.o_tx_data;
    end
  end

  int last_valid;
  int vcount;

  initial begin
    tx_if.i_tx_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h9E3779B9 * 32'(i + 1);
    mem[0]    = 32'hDEADBEEF;
    mem[32]   = 32'h01020304;
    mem[33]   = 32'h10203040;

    vecs[0] = '{12'h00D, 11'd2, 1'b0, 0};
    vecs[1] = '{12'hFFC, 11'd2, 1'b1, 0};
    vecs[2] = '{12'h040, 11'd5, 1'b0, 1};
    vecs[3] = '{12'h3F1, 11'd3, 1'b1, 1};
    vecs[4] = '{12'h000, 11'd0, 1'b0, 0};
    vecs[5] = '{12'hFF8, 11'd4, 1'b0, 1};

    // Reset values.
    i_rst = 1'b1;
    step(); step();
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_tx_data", 32'(tx_if.o_tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_if.o_tx_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    i_rst = 1'b0;
    step();

    // Cycle-exact single word, ready always high.
    ready_mode = 0;
    push_byte(8'hDE, 12'h000, 1'b1);
    push_byte(8'hAD, 12'h000, 1'b1);
    push_byte(8'hBE, 12'h000, 1'b1);
    push_byte(8'hEF, 12'h000, 1'b1);
`ifdef DUMP_CHECKSUM_EN
    push_byte(8'h22, 12'h000, 1'b0);
    last_valid = 7;
`else
    last_valid = 6;
`endif
    pulse_start(12'h000, 11'd1);
    for (int k = 1; k <= last_valid + 2; k++) begin
      chk($sformatf("t1_valid_c%0d", k), 32'(tx_if.o_tx_valid), 32'(k >= 3 && k <= last_valid));
      chk($sformatf("t1_done_c%0d", k), 32'(o_done), 32'(k == last_valid + 1));
      chk($sformatf("t1_busy_c%0d", k), 32'(o_busy), 32'(k >= 1 && k <= last_valid));
      step();
    end
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Table of dumps checked against the memory model.
    for (int v = 0; v < 6; v++) begin
      ready_mode = vecs[v].rmode;
      push_model(vecs[v].base, int'(vecs[v].count));
      pulse_start(vecs[v].base, vecs[v].count);
      wait_done(vecs[v].mid_start, $sformatf("vec%0d", v));
    end

    // Back-pressure on the second byte for five cycles.
    ready_mode = 2;
    tx_if.i_tx_ready = 1'b1;
    push_model(12'h000, 1);
    pulse_start(12'h000, 11'd1);
    step(); step(); step();
    tx_if.i_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", 32'(tx_if.o_tx_data), 32'h0000_00AD);
      chk("stall_valid", 32'(tx_if.o_tx_valid), 32'd1);
      step();
    end
    tx_if.i_tx_ready = 1'b1;
    wait_done(1'b0, "stall");
    ready_mode = 0;

    // Reset while streaming abandons the dump without a done pulse.
    push_model(12'h100, 3);
    pulse_start(12'h100, 11'd3);
    vcount = 0;
    while (!tx_if.o_tx_valid && vcount < 20) begin step(); vcount++; end
    chk("rst_mid_reached_send", 32'(tx_if.o_tx_valid), 32'd1);
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("rst_mid_valid", 32'(tx_if.o_tx_valid), 32'd0);
    chk("rst_mid_busy", 32'(o_busy), 32'd0);
    chk("rst_mid_done", 32'(o_done), 32'd0);
    sb_q.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_after_done", 32'(o_done), 32'd0);
      chk("rst_after_valid", 32'(tx_if.o_tx_valid), 32'd0);
    end

`ifdef DUMP_CHECKSUM_EN
    // Checksum trailer: 01^02^03^04^10^20^30^40 = 44; zero-word dump emits only 00.
    push_byte(8'h01, 12'h080, 1'b1); push_byte(8'h02, 12'h080, 1'b1);
    push_byte(8'h03, 12'h080, 1'b1); push_byte(8'h04, 12'h080, 1'b1);
    push_byte(8'h10, 12'h084, 1'b1); push_byte(8'h20, 12'h084, 1'b1);
    push_byte(8'h30, 12'h084, 1'b1); push_byte(8'h40, 12'h084, 1'b1);
    push_byte(8'h44, 12'h000, 1'b0);
    pulse_start(12'h080, 11'd2);
    wait_done(1'b0, "csum2");
    push_byte(8'h00, 12'h000, 1'b0);
    pulse_start(12'h050, 11'd0);
    wait_done(1'b0, "csum0");
`endif

    step(); step();
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_dumper.md
# data_mem_dumper

Streams a contiguous range of the byte-addressed data memory out as bytes for the debug unit. It reads whole words through the memory's read port and serializes each word most-significant byte first, which matches the memory's byte order: MSB at the lowest address. Output is a valid/ready byte stream feeding the debug UART transmitter. The block is the reader counterpart of the word-write/byte-store data memory.

## Interface
- NB_DATA, 32, memory word width; must be 4 × NB_BYTE
- NB_ADDR, 12, byte-address width of the data memory
- NB_BYTE, 8, stream byte width
- clk  in  1  single clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request to begin a dump; ignored while o_busy
- i_base_addr  in  NB_ADDR  first byte address; bits [1:0] forced to 0
- i_word_count  in  NB_ADDR-1  number of words to dump, 0..2**(NB_ADDR-2)
- o_mem_addr  out  NB_ADDR  registered word-aligned read address to memory
- i_mem_data  in  NB_DATA  memory read data; combinational from o_mem_addr
- o_tx_data  out  NB_BYTE  stream byte
- o_tx_valid  out  1  stream byte valid
- i_tx_ready  in  1  consumer accepts byte when valid && ready
- o_busy  out  1  high from the cycle after an accepted start until DONE
- o_done  out  1  one-cycle pulse at end of a dump

## Operation
- States: IDLE, ADDR, LOAD, SEND, [CSUM], DONE.
- IDLE: i_start latches base (low 2 bits cleared) into o_mem_addr and the count into the remaining counter -> ADDR. If the count is 0 -> DONE directly (via CSUM when enabled).
- ADDR: one settle cycle with o_mem_addr stable -> LOAD.
- LOAD: capture i_mem_data into a 4-byte shift register; byte index = 0 -> SEND.
- SEND: o_tx_valid = 1 and o_tx_data = shift[NB_DATA-1 -: NB_BYTE].
  - On handshake: shift left by NB_BYTE and increment the byte index.
  - After the 4th handshake: decrement remaining. If nonzero, o_mem_addr += 4 -> ADDR. Else -> CSUM if enabled, otherwise DONE.
- DONE: o_done = 1 for one cycle -> IDLE.
- Address arithmetic is modulo 2**NB_ADDR; a dump past the top wraps to 0.
- o_tx_data and o_tx_valid hold steady while valid && !ready; valid never drops without a handshake.
- i_start is ignored in any state other than IDLE.
- Reset at any point: state IDLE, no o_done pulse, partial dump abandoned.

## Timing
- Reset values: o_mem_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
- Start accepted at cycle 0 -> ADDR at cycle 1, LOAD at cycle 2, first o_tx_valid at cycle 3.
- With i_tx_ready held high: 6 cycles per word (ADDR, LOAD, 4 × SEND).
- o_done asserts the cycle after the last byte handshake, or after the CSUM handshake when enabled.
- o_busy is low in the same cycle o_done is high.

## Configuration
- DUMP_CHECKSUM_EN defined: the CSUM state emits one extra byte, the XOR of all streamed data bytes (0x00 for a zero-word dump), with the same handshake rules.
- Not defined: no CSUM state; the stream contains exactly 4 × word_count bytes.

## Structure
- Shared package mips_dbg_pkg holds the state encoding, NB_BYTE, BYTES_PER_WORD = 4, and the checksum seed 0x00.
- One sub-module, word_serializer, is natural. It holds the shift register, byte index, handshake and the last-byte flag, and is parameterized by NB_DATA and NB_BYTE.

## Test plan
- Memory word 0x00 = 0xDEADBEEF; base 0, count 1, ready always high -> bytes DE AD BE EF on cycles 3–6; o_done on cycle 7.
- Base 0x00D (unaligned), count 2 -> reads start at 0x00C, then 0x010; 8 bytes emitted in order.
- Ready low for 5 cycles on the 2nd byte -> o_tx_data stays 0xAD and valid stays high; no byte is lost or duplicated.
- Base 0xFFC, count 2 -> second read at 0x000 (wrap); i_start pulsed mid-dump has no effect.
- Reset asserted during SEND -> next cycle o_tx_valid=0 and o_busy=0; no o_done pulse.
- With DUMP_CHECKSUM_EN: words 0x01020304 and 0x10203040 -> 9th byte 0x44; count 0 -> a single byte 0x00, then o_done.
